// File: rtl/sd_cmd_issuer_pkg.sv
// Shared definitions for the SD command issuer: response-type codes, host
// phase codes, setting-word field positions, response sizes and the helpers
// that build the command and setting words.
package sd_cmd_issuer_pkg;

  // Response type codes as presented on rsp_type_i
  localparam logic [1:0] RSP_NONE        = 2'b00;
  localparam logic [1:0] RSP_SHORT       = 2'b01;
  localparam logic [1:0] RSP_LONG        = 2'b10;
  localparam logic [1:0] RSP_SHORT_NOCRC = 2'b11;

  // Host phase codes reported in host_status_i[3:0]
  localparam logic [3:0] PHASE_1 = 4'd1;
  localparam logic [3:0] PHASE_2 = 4'd2;
  localparam logic [3:0] PHASE_3 = 4'd3;
  localparam logic [3:0] PHASE_4 = 4'd4;
  localparam logic [3:0] PHASE_5 = 4'd5;
  localparam logic [3:0] PHASE_6 = 4'd6;

  // Status byte flag positions
  localparam int STAT_CRC_OK_BIT = 5;
  localparam int STAT_FINAL_BIT  = 6;

  // Setting word field positions
  localparam int SET_SIZE_LSB  = 0;
  localparam int SET_CRC_BIT   = 7;
  localparam int SET_DELAY_LSB = 8;
  localparam int SET_WR_BIT    = 11;
  localparam int SET_RD_BIT    = 12;
  localparam int SET_WSEL_LSB  = 13;

  // Response sizes in bits
  localparam logic [6:0] RSP_SIZE_NONE  = 7'd0;
  localparam logic [6:0] RSP_SIZE_SHORT = 7'd40;
  localparam logic [6:0] RSP_SIZE_LONG  = 7'd127;

  // Start and transmission bits that prefix every command word
  localparam logic [1:0] CMD_PREFIX = 2'b01;

  // Response length for a given response type
  function automatic logic [6:0] rsp_size(input logic [1:0] rsp_type);
    logic [6:0] size;
    case (rsp_type)
      RSP_NONE:  size = RSP_SIZE_NONE;
      RSP_LONG:  size = RSP_SIZE_LONG;
      default:   size = RSP_SIZE_SHORT;
    endcase
    return size;
  endfunction

  // CRC checking applies to the short and long CRC-protected responses only
  function automatic logic crc_on(input logic [1:0] rsp_type);
    return (rsp_type == RSP_SHORT) || (rsp_type == RSP_LONG);
  endfunction

  // Assemble the 16-bit host setting word
  function automatic logic [15:0] build_setting(input logic [1:0] word_sel,
                                                input logic       block_rd,
                                                input logic       block_wr,
                                                input logic [2:0] delay,
                                                input logic [1:0] rsp_type);
    logic [15:0] s;
    s = 16'h0000;
    s[SET_WSEL_LSB +: 2]  = word_sel;
    s[SET_RD_BIT]         = block_rd;
    s[SET_WR_BIT]         = block_wr;
    s[SET_DELAY_LSB +: 3] = delay;
    s[SET_CRC_BIT]        = crc_on(rsp_type);
    s[SET_SIZE_LSB +: 7]  = rsp_size(rsp_type);
    return s;
  endfunction

  // Assemble the 40-bit host command word
  function automatic logic [39:0] build_cmd(input logic [5:0]  cmd_index,
                                            input logic [31:0] cmd_arg);
    return {CMD_PREFIX, cmd_index, cmd_arg};
  endfunction

endpackage

// File: rtl/sd_cmd_issuer_status_ack.sv
// Four-phase phase-status responder: latches the host status byte on a new
// request and holds host_ack_o until the host withdraws its request.
module sd_cmd_status_ack (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clear,
  input  logic       i_req,
  input  logic [7:0] i_status,
  output logic       o_ack,
  output logic [7:0] o_status,
  output logic       o_latch
);

  logic       r_ack;
  logic [7:0] r_status;
  logic       w_latch;

  // A new status is accepted only while enabled and not already acknowledging
  assign w_latch = i_en & ~i_clear & i_req & ~r_ack;

  // Status latch and acknowledge flag; clear forces the ack low immediately
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack    <= 1'b0;
      r_status <= 8'h00;
    end else if (i_clear) begin
      r_ack    <= 1'b0;
    end else if (w_latch) begin
      r_ack    <= 1'b1;
      r_status <= i_status;
    end else if (!i_req) begin
      r_ack    <= 1'b0;
    end else begin
      r_ack    <= r_ack;
    end
  end

  assign o_ack    = r_ack;
  assign o_status = r_status;
  assign o_latch  = w_latch;

endmodule

// File: rtl/sd_cmd_issuer.sv
// SD command issuer: builds the command and setting words, runs the REQ/ACK
// issue handshake, acknowledges host phase status, captures the response and
// recovers a hung host by timeout plus a host reset pulse.
// Optional feature macro: SD_CMD_RSP_INDEX_CHECK_EN enables the short-response
// index comparison reported in err_o[2].
module sd_cmd_issuer
  import sd_cmd_issuer_pkg::*;
#(
  parameter int TIMEOUT_W       = 16,
  parameter int HOST_RST_CYCLES = 4
) (
  input  logic                 SD_CLK_IN,
  input  logic                 RST_IN,
  input  logic                 start_i,
  input  logic [5:0]           cmd_index_i,
  input  logic [31:0]          cmd_arg_i,
  input  logic [1:0]           rsp_type_i,
  input  logic [2:0]           delay_i,
  input  logic                 block_rd_i,
  input  logic                 block_wr_i,
  input  logic [1:0]           word_sel_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [3:0]           err_o,
  output logic [39:0]          rsp_o,
  output logic [3:0]           phase_o,
  output logic [15:0]          host_setting_o,
  output logic [39:0]          host_cmd_o,
  output logic                 host_req_o,
  input  logic                 host_ack_i,
  input  logic                 host_req_i,
  output logic                 host_ack_o,
  input  logic [7:0]           host_status_i,
  input  logic [39:0]          host_rsp_i,
  output logic                 host_rst_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_FINISH  = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam int                   RST_CW   = $clog2(HOST_RST_CYCLES) + 1;
  localparam logic [RST_CW-1:0]    RST_LAST = RST_CW'(HOST_RST_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_MAX   = {TIMEOUT_W{1'b1}};

  logic [2:0]           r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [2:0]           r_err;
  logic [39:0]          r_rsp;
  logic [15:0]          r_host_setting;
  logic [39:0]          r_host_cmd;
  logic                 r_host_req;
  logic                 r_host_rst;
  logic                 r_final;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [RST_CW-1:0]    r_rst_cnt;

  logic       w_sts_en;
  logic       w_sts_clear;
  logic       w_latch;
  logic [7:0] w_status;
  logic       w_final_latch;
  logic       w_timeout;
  logic       w_counting;
  logic       w_phase6;
  logic       w_crc_err;
  logic       w_idx_err;

  assign w_counting  = (r_state == ST_ISSUE) || (r_state == ST_RUN);
  assign w_sts_en    = w_counting;
  assign w_sts_clear = w_timeout || (r_state == ST_RECOVER);

  sd_cmd_status_ack u_status_ack (
    .i_clk    (SD_CLK_IN),
    .i_rst    (RST_IN),
    .i_en     (w_sts_en),
    .i_clear  (w_sts_clear),
    .i_req    (host_req_i),
    .i_status (host_status_i),
    .o_ack    (host_ack_o),
    .o_status (w_status),
    .o_latch  (w_latch)
  );

  // A status being latched this cycle that marks the end of the command
  assign w_final_latch = w_latch && host_status_i[STAT_FINAL_BIT] &&
                         ((host_status_i[3:0] == PHASE_6) || (host_status_i[3:0] == PHASE_4));

  // Timeout fires on the exact limit; a simultaneous final status takes priority
  assign w_timeout = w_counting && (timeout_i != {TIMEOUT_W{1'b0}}) &&
                     (r_to_cnt == timeout_i) && !w_final_latch;

  assign w_phase6  = (w_status[3:0] == PHASE_6);
  assign w_crc_err = r_host_setting[SET_CRC_BIT] && !w_status[STAT_CRC_OK_BIT];

`ifdef SD_CMD_RSP_INDEX_CHECK_EN
  // Index check only for short CRC responses (crc on and 40-bit length)
  assign w_idx_err = r_host_setting[SET_CRC_BIT] &&
                     (r_host_setting[SET_SIZE_LSB +: 7] == RSP_SIZE_SHORT) &&
                     (host_rsp_i[37:32] != r_host_cmd[37:32]);
`else
  assign w_idx_err = 1'b0;
`endif

  // Command sequencer: issue handshake, run, capture, recovery and completion
  always_ff @(posedge SD_CLK_IN) begin
    if (RST_IN) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 3'b000;
      r_rsp          <= 40'h00_0000_0000;
      r_host_setting <= 16'h0000;
      r_host_cmd     <= 40'h00_0000_0000;
      r_host_req     <= 1'b0;
      r_host_rst     <= 1'b0;
      r_final        <= 1'b0;
      r_to_cnt       <= {TIMEOUT_W{1'b0}};
      r_rst_cnt      <= {RST_CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_i && host_ack_i) begin
            r_host_cmd     <= build_cmd(cmd_index_i, cmd_arg_i);
            r_host_setting <= build_setting(word_sel_i, block_rd_i, block_wr_i,
                                            delay_i, rsp_type_i);
            r_busy         <= 1'b1;
            r_err          <= 3'b000;
            r_host_req     <= 1'b1;
            r_final        <= 1'b0;
            r_to_cnt       <= {TIMEOUT_W{1'b0}};
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_RUN: begin
          if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
          end
          if (w_final_latch) begin
            r_final <= 1'b1;
          end
          if (w_timeout) begin
            r_err[0]   <= 1'b1;
            r_host_req <= 1'b0;
            r_host_rst <= 1'b1;
            r_rst_cnt  <= {RST_CW{1'b0}};
            r_state    <= ST_RECOVER;
          end else if (r_state == ST_ISSUE) begin
            // Drop the request only once the host has left idle
            if (!host_ack_i) begin
              r_host_req <= 1'b0;
              r_state    <= ST_RUN;
            end
          end else if (r_final && !host_req_i && host_ack_i) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (w_phase6) begin
            r_rsp    <= host_rsp_i;
            r_err[1] <= w_crc_err;
            r_err[2] <= w_idx_err;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_RECOVER: begin
          r_rst_cnt <= r_rst_cnt + RST_CW'(1);
          if (r_rst_cnt == RST_LAST) begin
            r_host_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = {1'b0, r_err};
  assign rsp_o          = r_rsp;
  assign phase_o        = w_status[3:0];
  assign host_setting_o = r_host_setting;
  assign host_cmd_o     = r_host_cmd;
  assign host_req_o     = r_host_req;
  assign host_rst_o     = r_host_rst;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Self-checking bench for sd_cmd_issuer: directed commands against a
// rule-level model of the expected words, errors and response.
module tb_sd_cmd_issuer;

  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          RST_IN;
  logic          start_i;
  logic [5:0]    cmd_index_i;
  logic [31:0]   cmd_arg_i;
  logic [1:0]    rsp_type_i;
  logic [2:0]    delay_i;
  logic          block_rd_i, block_wr_i;
  logic [1:0]    word_sel_i;
  logic [TW-1:0] timeout_i;
  logic          busy_o, done_o;
  logic [3:0]    err_o;
  logic [39:0]   rsp_o;
  logic [3:0]    phase_o;
  logic [15:0]   host_setting_o;
  logic [39:0]   host_cmd_o;
  logic          host_req_o;
  logic          host_ack_i;
  logic          host_req_i;
  logic          host_ack_o;
  logic [7:0]    host_status_i;
  logic [39:0]   host_rsp_i;
  logic          host_rst_o;

  sd_cmd_issuer #(.TIMEOUT_W(TW), .HOST_RST_CYCLES(4)) dut (
    .SD_CLK_IN(clk), .RST_IN(RST_IN), .start_i(start_i),
    .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .rsp_type_i(rsp_type_i),
    .delay_i(delay_i), .block_rd_i(block_rd_i), .block_wr_i(block_wr_i),
    .word_sel_i(word_sel_i), .timeout_i(timeout_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rsp_o(rsp_o), .phase_o(phase_o),
    .host_setting_o(host_setting_o), .host_cmd_o(host_cmd_o), .host_req_o(host_req_o),
    .host_ack_i(host_ack_i), .host_req_i(host_req_i), .host_ack_o(host_ack_o),
    .host_status_i(host_status_i), .host_rsp_i(host_rsp_i), .host_rst_o(host_rst_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_done = 0, n_accept = 0;
  int cyc = 0, start_cyc = 0, err_cyc = -1, rst_hi = 0;

  // Model state
  logic        exp_active = 1'b0, exp_timeout = 1'b0;
  logic [39:0] exp_cmd = 40'h0, exp_rsp = 40'h0;
  logic [15:0] exp_set = 16'h0;
  logic [3:0]  exp_err = 4'h0, exp_phase = 4'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Setting word from the field rules
  function automatic logic [15:0] m_setting(input logic [1:0] ws, input logic rd, input logic wr,
                                            input logic [2:0] dly, input logic [1:0] rt);
    logic [6:0] size;
    logic       crc;
    size = (rt == 2'b00) ? 7'd0 : ((rt == 2'b10) ? 7'd127 : 7'd40);
    crc  = (rt == 2'b01) || (rt == 2'b10);
    return {1'b0, ws, rd, wr, dly, crc, size};
  endfunction

  // Error word from the completion rules
  function automatic logic [3:0] m_err(input logic [1:0] rt, input logic final6, input logic crc_ok,
                                       input logic [39:0] rsp, input logic [5:0] idx,
                                       input logic timed_out);
    logic [3:0] e;
    logic [5:0] ri;
    e  = 4'b0000;
    ri = rsp[37:32];
    if (timed_out) begin
      e[0] = 1'b1;
    end else if (final6) begin
      if (((rt == 2'b01) || (rt == 2'b10)) && !crc_ok) e[1] = 1'b1;
`ifdef SD_CMD_RSP_INDEX_CHECK_EN
      if ((rt == 2'b01) && (ri != idx)) e[2] = 1'b1;
`else
      if (ri == idx) e[2] = 1'b0;
`endif
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (!RST_IN) begin
      if (busy_o) begin
        chk("cmd_word", host_cmd_o, exp_cmd);
        chk("setting_word", host_setting_o, exp_set);
      end
      if (host_rst_o) begin
        rst_hi++;
        chk("host_rst_unexpected", exp_timeout, 1'b1);
        chk("rst_forces_req", host_req_o, 1'b0);
        chk("rst_forces_ack", host_ack_o, 1'b0);
      end
      if (err_o[0] && err_cyc < 0) err_cyc = cyc;
      if (done_o) begin
        n_done++;
        chk("done_while_expected", exp_active, 1'b1);
        chk("done_busy", busy_o, 1'b0);
        chk("done_err", err_o, exp_err);
        chk("done_phase", phase_o, exp_phase);
        chk("done_rsp", rsp_o, exp_rsp);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic [2:0] dly, input logic rd, input logic wr,
                       input logic [1:0] ws, input logic [TW-1:0] to);
    cmd_index_i = idx; cmd_arg_i = arg; rsp_type_i = rt; delay_i = dly;
    block_rd_i = rd; block_wr_i = wr; word_sel_i = ws; timeout_i = to;
  endtask

  task automatic pulse_start;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_req_o(input logic v, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (host_req_o === v) begin ok = 1'b1; break; end
      step();
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_ack_o(input logic v, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (host_ack_o === v) begin ok = 1'b1; break; end
      step();
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_done;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_o === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_done", ok, 1'b1);
    step();
    exp_active = 1'b0;
    step();
    chk("done_count", n_done, n_accept);
  endtask

  task automatic host_accept;
    wait_req_o(1'b1, "issue_req_high");
    host_ack_i = 1'b0;
    wait_req_o(1'b0, "issue_req_drop");
  endtask

  task automatic host_phase(input logic [7:0] st);
    host_status_i = st;
    host_req_i    = 1'b1;
    wait_ack_o(1'b1, "phase_ack_set");
    host_req_i    = 1'b0;
    wait_ack_o(1'b0, "phase_ack_clr");
  endtask

  // One complete command against a well-behaved host
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [2:0] dly, input logic rd, input logic wr,
                         input logic [1:0] ws, input logic [TW-1:0] to,
                         input logic [31:0] phs, input int nph, input logic [39:0] rsp,
                         input logic [39:0] lit_cmd, input logic [15:0] lit_set,
                         input bit restart_busy);
    logic [7:0] fs;
    logic       final6;
    fs     = phs[8*(nph-1) +: 8];
    final6 = (fs[3:0] == 4'd6);
    exp_cmd     = {2'b01, idx, arg};
    exp_set     = m_setting(ws, rd, wr, dly, rt);
    exp_err     = m_err(rt, final6, fs[5], rsp, idx, 1'b0);
    exp_phase   = fs[3:0];
    if (final6) exp_rsp = rsp;
    exp_timeout = 1'b0;
    exp_active  = 1'b1;
    drive(idx, arg, rt, dly, rd, wr, ws, to);
    host_rsp_i = rsp;
    pulse_start();
    n_accept++;
    chk("start_busy", busy_o, 1'b1);
    chk("lit_cmd", host_cmd_o, lit_cmd);
    chk("lit_setting", host_setting_o, lit_set);
    if (restart_busy) begin
      drive(6'd5, 32'hDEAD_BEEF, 2'b10, 3'd7, 1'b1, 1'b1, 2'd3, to);
      pulse_start();
    end
    host_accept();
    for (int i = 0; i < nph; i++) host_phase(phs[8*i +: 8]);
    host_ack_i = 1'b1;
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_IN = 1'b1; start_i = 1'b0; host_ack_i = 1'b1; host_req_i = 1'b0;
    host_status_i = 8'h00; host_rsp_i = 40'h0;
    drive(6'd0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    step(); step(); step();
    // Reset state
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 4'h0);
    chk("rst_rsp", rsp_o, 40'h0);
    chk("rst_phase", phase_o, 4'h0);
    chk("rst_setting", host_setting_o, 16'h0);
    chk("rst_cmd", host_cmd_o, 40'h0);
    chk("rst_host_req", host_req_o, 1'b0);
    chk("rst_host_ack", host_ack_o, 1'b0);
    chk("rst_host_rst", host_rst_o, 1'b0);
    RST_IN = 1'b0;
    step();

    // CMD0, no response, delay 3: phases 2 then final 4
    run_cmd(6'd0, 32'h0, 2'b00, 3'd3, 1'b0, 1'b0, 2'd0, 16'd0,
            32'h0000_4402, 2, 40'h0, 40'h40_0000_0000, 16'h0300, 1'b0);

    // CMD17 arg 0x200, short CRC response, CRC good; a second start while busy is ignored
    run_cmd(6'd17, 32'h200, 2'b01, 3'd0, 1'b1, 1'b0, 2'd0, 16'd1000,
            32'h6605_0301, 4, 40'h11_0000_0900, 40'h51_0000_0200, 16'h10A8, 1'b1);

    // Same with corrupted CRC
    run_cmd(6'd17, 32'h200, 2'b01, 3'd0, 1'b1, 1'b0, 2'd0, 16'd1000,
            32'h4605_0301, 4, 40'h11_0000_0A00, 40'h51_0000_0200, 16'h10A8, 1'b0);

    // Response index 16 for CMD17: flagged only with the index check compiled in
    run_cmd(6'd17, 32'h200, 2'b01, 3'd0, 1'b1, 1'b0, 2'd0, 16'd1000,
            32'h6605_0301, 4, 40'h10_0000_0900, 40'h51_0000_0200, 16'h10A8, 1'b0);

    // Long response, word select 2
    run_cmd(6'd2, 32'h0, 2'b10, 3'd0, 1'b0, 1'b0, 2'd2, 16'd1000,
            32'h6605_0301, 4, 40'h3F_1234_5678, 40'h42_0000_0000, 16'h40FF, 1'b0);

    // Short response without CRC: bad CRC flag is not an error
    run_cmd(6'd3, 32'h1234_5678, 2'b11, 3'd0, 1'b0, 1'b1, 2'd0, 16'd1000,
            32'h4605_0301, 4, 40'h03_AAAA_5555, 40'h43_1234_5678, 16'h0828, 1'b0);

    // Timeout: host accepts, reports phase 1 then hangs
    exp_cmd     = {2'b01, 6'd17, 32'h200};
    exp_set     = m_setting(2'd0, 1'b1, 1'b0, 3'd0, 2'b01);
    exp_err     = m_err(2'b01, 1'b0, 1'b0, 40'h0, 6'd17, 1'b1);
    exp_phase   = 4'd1;
    exp_timeout = 1'b1;
    exp_active  = 1'b1;
    err_cyc     = -1;
    rst_hi      = 0;
    drive(6'd17, 32'h200, 2'b01, 3'd0, 1'b1, 1'b0, 2'd0, 16'd100);
    pulse_start();
    start_cyc = cyc;
    n_accept++;
    chk("to_lit_cmd", host_cmd_o, 40'h51_0000_0200);
    host_accept();
    host_phase(8'h01);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (host_rst_o === 1'b1) begin seen = 1'b1; break; end
        step();
      end
      chk("host_rst_seen", seen, 1'b1);
    end
    host_ack_i = 1'b1;
    wait_done();
    chk("timeout_cycles", err_cyc - start_cyc, 101);
    chk("host_rst_cycles", rst_hi, 4);
    chk("idle_after_recover", busy_o, 1'b0);
    exp_timeout = 1'b0;

    // Start together with reset: reset wins
    RST_IN = 1'b1;
    start_i = 1'b1;
    drive(6'd8, 32'h1AA, 2'b01, 3'd0, 1'b0, 1'b0, 2'd0, 16'd0);
    step();
    RST_IN = 1'b0;
    start_i = 1'b0;
    exp_rsp = 40'h0;
    step();
    chk("rst_start_busy", busy_o, 1'b0);
    chk("rst_start_req", host_req_o, 1'b0);
    chk("rst_start_rsp", rsp_o, 40'h0);
    chk("rst_start_err", err_o, 4'h0);

    // Start while the host is not idle is ignored
    host_ack_i = 1'b0;
    pulse_start();
    step();
    chk("start_host_busy", busy_o, 1'b0);
    chk("start_host_busy_req", host_req_o, 1'b0);
    host_ack_i = 1'b1;
    step(); step();
    chk("final_done_count", n_done, n_accept);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
